// File: rtl/router_sync_n.sv
// N-channel router synchroniser: latches the header address, steers the write
// enable to one FIFO, muxes its full flag and times out unread FIFOs.

module router_sync_n_tmo #(
  parameter int TIMEOUT = 30
) (
  input  logic clk,
  input  logic resetn,
  input  logic stall,
  output logic soft_reset
);
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  // Count restarts at zero after each pulse so a persistent stall repeats
  // every TIMEOUT cycles; any non-stalled edge wipes the count.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt        <= '0;
      soft_reset <= 1'b0;
    end else if (stall) begin
      if (cnt == CW'(TIMEOUT - 1)) begin
        cnt        <= '0;
        soft_reset <= 1'b1;
      end else begin
        cnt        <= cnt + 1'b1;
        soft_reset <= 1'b0;
      end
    end else begin
      cnt        <= '0;
      soft_reset <= 1'b0;
    end
  end
endmodule

module router_sync_n #(
  parameter int NUM_CH  = 3,
  parameter int ADDR_W  = 2,
  parameter int TIMEOUT = 30
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              detect_add,
  input  logic [ADDR_W-1:0] data_in,
  input  logic              write_enb_reg,
  input  logic [NUM_CH-1:0] full,
  input  logic [NUM_CH-1:0] empty,
  input  logic [NUM_CH-1:0] read_enb,
  output logic              fifo_full,
  output logic [NUM_CH-1:0] write_enb,
  output logic [NUM_CH-1:0] vld_out,
  output logic [NUM_CH-1:0] soft_reset,
  output logic              addr_err
);
  // One extra bit so NUM_CH == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] CH_LIM = (ADDR_W + 1)'(NUM_CH);

  logic [ADDR_W-1:0] addr_reg;
  logic              addr_valid;
  logic              in_range;

  assign in_range = {1'b0, data_in} < CH_LIM;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_reg   <= '0;
      addr_valid <= 1'b0;
      addr_err   <= 1'b0;
    end else if (detect_add) begin
      addr_reg   <= data_in;
      addr_valid <= in_range;
      addr_err   <= ~in_range;
    end
  end

  // Out-of-range addresses decode to nothing, so writes are dropped.
  always_comb begin
    write_enb = '0;
    fifo_full = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (addr_valid && addr_reg == ADDR_W'(i)) begin
        write_enb[i] = write_enb_reg;
        fifo_full    = full[i];
      end
    end
  end

  assign vld_out = ~empty;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    router_sync_n_tmo #(.TIMEOUT(TIMEOUT)) u_tmo (
      .clk        (clk),
      .resetn     (resetn),
      .stall      (vld_out[g] & ~read_enb[g]),
      .soft_reset (soft_reset[g])
    );
  end
endmodule

// File: tb/tb_router_sync_n.sv
// Bench for router_sync_n: default 3-channel instance plus a 4-channel,
// TIMEOUT=2 instance sharing clock and reset.

module tb_router_sync_n;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic       detect_add, write_enb_reg, fifo_full, addr_err;
  logic [1:0] data_in;
  logic [2:0] full, empty, read_enb, write_enb, vld_out, soft_reset;

  logic       detect_add4, write_enb_reg4, fifo_full4, addr_err4;
  logic [1:0] data_in4;
  logic [3:0] full4, empty4, read_enb4, write_enb4, vld_out4, soft_reset4;

  router_sync_n dut (
    .clk(clk), .resetn(resetn), .detect_add(detect_add), .data_in(data_in),
    .write_enb_reg(write_enb_reg), .full(full), .empty(empty), .read_enb(read_enb),
    .fifo_full(fifo_full), .write_enb(write_enb), .vld_out(vld_out),
    .soft_reset(soft_reset), .addr_err(addr_err)
  );

  router_sync_n #(.NUM_CH(4), .ADDR_W(2), .TIMEOUT(2)) dut4 (
    .clk(clk), .resetn(resetn), .detect_add(detect_add4), .data_in(data_in4),
    .write_enb_reg(write_enb_reg4), .full(full4), .empty(empty4), .read_enb(read_enb4),
    .fifo_full(fifo_full4), .write_enb(write_enb4), .vld_out(vld_out4),
    .soft_reset(soft_reset4), .addr_err(addr_err4)
  );

  int compared = 0;
  int mismatched = 0;
  int rl0[3];
  int rl4[4];

  typedef struct {
    logic [2:0] sr0;
    logic [3:0] sr4;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Expected soft_reset comes from stall run lengths: a pulse follows every
  // TIMEOUT-th consecutive stalled edge.
  task automatic cycle();
    exp_t e;
    for (int i = 0; i < 3; i++) begin
      if (resetn && !empty[i] && !read_enb[i]) rl0[i]++; else rl0[i] = 0;
      e.sr0[i] = (rl0[i] != 0) && (rl0[i] % 30 == 0);
    end
    for (int i = 0; i < 4; i++) begin
      if (resetn && !empty4[i] && !read_enb4[i]) rl4[i]++; else rl4[i] = 0;
      e.sr4[i] = (rl4[i] != 0) && (rl4[i] % 2 == 0);
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk("soft_reset", 32'(soft_reset), 32'(e.sr0));
    chk("soft_reset4", 32'(soft_reset4), 32'(e.sr4));
  endtask

  initial begin
    detect_add = 0; write_enb_reg = 0; data_in = 0;
    full = 0; empty = 3'b111; read_enb = 0;
    detect_add4 = 0; write_enb_reg4 = 0; data_in4 = 0;
    full4 = 0; empty4 = 4'b1111; read_enb4 = 0;
    foreach (rl0[i]) rl0[i] = 0;
    foreach (rl4[i]) rl4[i] = 0;
    #1;
    chk("rst_addr_err", 32'(addr_err), 0);
    chk("rst_write_enb", 32'(write_enb), 0);
    chk("rst_fifo_full", 32'(fifo_full), 0);
    chk("rst_vld_out", 32'(vld_out), 0);
    cycle();
    resetn = 1;

    // valid address latch and steering
    detect_add = 1; data_in = 2'd1;
    detect_add4 = 1; data_in4 = 2'd3;
    cycle();
    detect_add = 0; detect_add4 = 0;
    write_enb_reg = 1; write_enb_reg4 = 1;
    #1;
    chk("we_ch1", 32'(write_enb), 32'b010);
    chk("err_ch1", 32'(addr_err), 0);
    chk("we4_ch3", 32'(write_enb4), 32'b1000);
    chk("err4_ch3", 32'(addr_err4), 0);
    full = 3'b010; #1;
    chk("ff_ch1", 32'(fifo_full), 1);
    full = 3'b001; #1;
    chk("ff_other", 32'(fifo_full), 0);
    full = 0;

    // simultaneous detect and write uses the old address
    detect_add = 1; data_in = 2'd2; #1;
    chk("we_old_addr", 32'(write_enb), 32'b010);
    cycle();
    detect_add = 0; #1;
    chk("we_new_addr", 32'(write_enb), 32'b100);

    // invalid address drops writes
    detect_add = 1; data_in = 2'd3;
    cycle();
    detect_add = 0; full = 3'b111; #1;
    chk("err_inv", 32'(addr_err), 1);
    chk("we_inv", 32'(write_enb), 0);
    chk("ff_inv", 32'(fifo_full), 0);
    detect_add = 1; data_in = 2'd0;
    cycle();
    detect_add = 0; #1;
    chk("err_clr", 32'(addr_err), 0);
    chk("we_ch0", 32'(write_enb), 32'b001);
    chk("ff_ch0", 32'(fifo_full), 1);
    full = 0;

    // continuous stall on channel 0: pulses after edges 30 and 60
    empty = 3'b110; empty4 = 4'b0111; #1;
    chk("vld_out", 32'(vld_out), 32'b001);
    chk("vld_out4", 32'(vld_out4), 32'b1000);
    repeat (65) cycle();
    empty = 3'b111;
    cycle();

    // one read at cycle 20 restarts the count
    empty = 3'b110;
    repeat (19) cycle();
    read_enb = 3'b001; #1;
    chk("vld_no_rd_path", 32'(vld_out), 32'b001);
    cycle();
    read_enb = 0;
    repeat (40) cycle();

    // channels 0 and 2 stalled, channel 1 read every cycle, reset at 15
    empty = 3'b010; read_enb = 3'b010; full = 3'b001;
    repeat (14) cycle();
    resetn = 0; #1;
    chk("arst_we", 32'(write_enb), 0);
    chk("arst_ff", 32'(fifo_full), 0);
    chk("arst_vld", 32'(vld_out), 32'b101);
    cycle();
    resetn = 1;
    repeat (30) cycle();
    chk("pulse_101", 32'(soft_reset), 32'b101);
    resetn = 0; #1;
    chk("arst_pulse", 32'(soft_reset), 0);
    cycle();
    resetn = 1;
    repeat (35) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
